difftest_fifo_checker: RTL

- Read-side counterpart of the DUT trace writer.
- Pops 128-bit {reg,pc} trace entries in lock-step from the DUT trace FIFO and the REF (golden model) trace FIFO, compares each pair, and reports pass/fail.
- Drives irq_dut_empty back to the DUT-side writer. This stalls the DUT when it runs ahead of the reference, and stalls it permanently on a mismatch.

---
 rtl/difftest_pkg.sv | 21 ++
 rtl/difftest_fifo_checker_dut_irq_throttle.sv | 43 ++++
 rtl/difftest_fifo_checker.sv | 123 ++++++++++++
 3 files changed

// File: rtl/difftest_pkg.sv
// Shared constants and state encoding for the difftest trace checker.
// Trace entries are {reg, pc}, with reg in the upper 64 bits.
package difftest_pkg;

  localparam int DATA_W             = 128;
  localparam int PC_LSB             = 0;
  localparam int PC_MSB             = 63;
  localparam int REG_LSB            = 64;
  localparam int REG_MSB            = 127;
  localparam int IRQ_MIN_CYCLES_DEF = 32;
  localparam int CNT_W_DEF          = 32;

  typedef enum logic [2:0] {
    CHK_IDLE = 3'd0,
    CHK_POP  = 3'd1,
    CHK_WAIT = 3'd2,
    CHK_CMP  = 3'd3,
    CHK_HALT = 3'd4
  } chk_state_t;

endpackage

// File: rtl/difftest_fifo_checker_dut_irq_throttle.sv
// Stall request to the DUT trace writer. Once raised, irq is held for at least
// IRQ_MIN_CYCLES cycles; halt pins it high until reset.
module dut_irq_throttle #(
  parameter int IRQ_MIN_CYCLES = difftest_pkg::IRQ_MIN_CYCLES_DEF
) (
  input  logic clk,
  input  logic resetn,
  input  logic ahead,
  input  logic halt,
  input  logic enable,
  output logic irq
);

  localparam int HW = $clog2(IRQ_MIN_CYCLES + 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(IRQ_MIN_CYCLES);

  logic          r_irq;
  logic [HW-1:0] r_hold;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_irq  <= 1'b0;
      r_hold <= '0;
    end else if (halt) begin
      r_irq <= 1'b1;
    end else if (!enable) begin
      r_irq  <= 1'b0;
      r_hold <= '0;
    end else if (!r_irq) begin
      if (ahead) begin
        r_irq  <= 1'b1;
        r_hold <= '0;
      end
    end else if ((r_hold >= HOLD_MAX) && !ahead) begin
      r_irq <= 1'b0;
    end else if (r_hold < HOLD_MAX) begin
      r_hold <= r_hold + 1'b1;
    end
  end

  assign irq = r_irq;

endmodule

// File: rtl/difftest_fifo_checker.sv
// Pops DUT and REF trace entries in lock-step, compares each pair and halts
// (with the DUT writer stalled) on the first mismatch.
module difftest_fifo_checker #(
  parameter int DATA_W         = difftest_pkg::DATA_W,
  parameter bit CMP_REG        = 1'b1,
  parameter int IRQ_MIN_CYCLES = difftest_pkg::IRQ_MIN_CYCLES_DEF,
  parameter int CNT_W          = difftest_pkg::CNT_W_DEF
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              enable,
  input  logic              dut_fifo_empty,
  input  logic [DATA_W-1:0] dut_fifo_rd_data,
  output logic              dut_fifo_rd_en,
  input  logic              ref_fifo_empty,
  input  logic [DATA_W-1:0] ref_fifo_rd_data,
  output logic              ref_fifo_rd_en,
  output logic              irq_dut_empty,
  output logic              right,
  output logic              mismatch,
  output logic [DATA_W-1:0] mismatch_dut_entry,
  output logic [DATA_W-1:0] mismatch_ref_entry,
  output logic [CNT_W-1:0]  compare_count,
  output logic [2:0]        out_state
);

  import difftest_pkg::*;

  chk_state_t        r_state;
  chk_state_t        w_next;
  logic              r_rd_en;
  logic              r_right;
  logic              r_mismatch;
  logic [DATA_W-1:0] r_mm_dut;
  logic [DATA_W-1:0] r_mm_ref;
  logic [CNT_W-1:0]  r_count;

  logic w_both_avail;
  logic w_pop;
  logic w_pc_eq;
  logic w_reg_eq;
  logic w_match;
  logic w_cmp;
  logic w_fail;
  logic w_ahead;
  logic w_halt;

  // Read data becomes valid in CHK_CMP (one cycle after the rd_en pulse that is
  // visible during CHK_WAIT), so the pair is compared straight off the ports.
  assign w_pc_eq  = (dut_fifo_rd_data[PC_MSB:PC_LSB] == ref_fifo_rd_data[PC_MSB:PC_LSB]);
  assign w_reg_eq = !CMP_REG ||
                    (dut_fifo_rd_data[REG_MSB:REG_LSB] == ref_fifo_rd_data[REG_MSB:REG_LSB]);
  assign w_match  = w_pc_eq && w_reg_eq;

  assign w_both_avail = !dut_fifo_empty && !ref_fifo_empty;
  assign w_pop        = (r_state == CHK_POP) && enable && w_both_avail;
  assign w_cmp        = (r_state == CHK_CMP);
  assign w_fail       = w_cmp && !w_match;
  assign w_ahead      = enable && !dut_fifo_empty && ref_fifo_empty;
  // Entering halt counts as halted so a same-cycle throttle release cannot drop irq.
  assign w_halt       = (r_state == CHK_HALT) || w_fail;

  always_ff @(posedge clk) begin
    if (!resetn) r_state <= CHK_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      CHK_IDLE: if (enable) w_next = CHK_POP;
      CHK_POP: begin
        if (!enable)          w_next = CHK_IDLE;
        else if (w_both_avail) w_next = CHK_WAIT;
      end
      CHK_WAIT: w_next = CHK_CMP;
      CHK_CMP:  w_next = w_match ? CHK_POP : CHK_HALT;
      CHK_HALT: w_next = CHK_HALT;
      default:  w_next = CHK_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_rd_en    <= 1'b0;
      r_right    <= 1'b1;
      r_mismatch <= 1'b0;
      r_mm_dut   <= '0;
      r_mm_ref   <= '0;
      r_count    <= '0;
    end else begin
      r_rd_en <= w_pop;
      if (w_cmp) r_count <= r_count + 1'b1;
      if (w_fail) begin
        r_right    <= 1'b0;
        r_mismatch <= 1'b1;
        r_mm_dut   <= dut_fifo_rd_data;
        r_mm_ref   <= ref_fifo_rd_data;
      end
    end
  end

  dut_irq_throttle #(
    .IRQ_MIN_CYCLES (IRQ_MIN_CYCLES)
  ) u_throttle (
    .clk    (clk),
    .resetn (resetn),
    .ahead  (w_ahead),
    .halt   (w_halt),
    .enable (enable),
    .irq    (irq_dut_empty)
  );

  assign dut_fifo_rd_en     = r_rd_en;
  assign ref_fifo_rd_en     = r_rd_en;
  assign right              = r_right;
  assign mismatch           = r_mismatch;
  assign mismatch_dut_entry = r_mm_dut;
  assign mismatch_ref_entry = r_mm_ref;
  assign compare_count      = r_count;
  assign out_state          = r_state;

endmodule
